core_spike_sequencer: RTL



---
 rtl/core_seq_pkg.sv | 39 +++
 rtl/lsb_prio_enc256.sv | 29 ++
 rtl/core_spike_sequencer.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/core_seq_pkg.sv
// core_seq_pkg
// Shared constants for the spike sequencer:
//   - array sizes of the neuron core (256 axons, 32 neurons, 9-bit address)
//   - default done_pic / output-word addresses
//   - FSM state encoding (3-bit) and the axon address helper
package core_seq_pkg;

  localparam int AXONS   = 256;
  localparam int NEURONS = 32;
  localparam int ADDR_W  = 9;

  localparam logic [ADDR_W-1:0] DEF_DONE_PIC_ADDR = 9'd448;
  localparam logic [ADDR_W-1:0] DEF_OUT_ADDR      = 9'd449;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_SCAN = 3'd1;
  localparam logic [2:0] ST_DONE = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_READ = 3'd4;
  localparam logic [2:0] ST_CAPT = 3'd5;
  localparam logic [2:0] ST_HOLD = 3'd6;

  typedef enum logic [2:0] {
    S_IDLE = ST_IDLE,
    S_SCAN = ST_SCAN,
    S_DONE = ST_DONE,
    S_WAIT = ST_WAIT,
    S_READ = ST_READ,
    S_CAPT = ST_CAPT,
    S_HOLD = ST_HOLD
  } seq_state_e;

  // 9-bit address of an axon write; wraps modulo 512.
  function automatic logic [ADDR_W-1:0] axon_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [7:0]        idx);
    return base + {1'b0, idx};
  endfunction

endpackage

// File: rtl/lsb_prio_enc256.sv
// lsb_prio_enc256
// Combinational lowest-set-bit encoder over a 256-bit vector.
// Ports:
//   vec      in  256  vector to search
//   idx      out 8    index of the lowest set bit (0 when vec is zero)
//   any      out 1    vec has at least one set bit
//   clr_mask out 256  one-hot mask of the lowest set bit (zero when vec is zero)
module lsb_prio_enc256
  import core_seq_pkg::*;
(
  input  logic [AXONS-1:0] vec,
  output logic [7:0]       idx,
  output logic             any,
  output logic [AXONS-1:0] clr_mask
);

  // Two's-complement trick isolates the lowest set bit.
  assign clr_mask = vec & (~vec + 256'd1);
  assign any      = |vec;

  // Scan from the top so the last hit (lowest index) wins.
  always_comb begin
    idx = '0;
    for (int i = AXONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = 8'(i);
    end
  end

endmodule

// File: rtl/core_spike_sequencer.sv
// core_spike_sequencer
// Upstream master for neuron_core_256x32: replays each set axon of an input
// frame as a write, strobes done_pic, waits, reads back the output spike word
// and presents it on a valid/ready interface.
// Ports:
//   clk_i, rst_i (async, active-high)
//   frame_valid_i / frame_ready_o / frame_i[255:0]   input frame handshake
//   core_en_o, core_we_o, core_addr_o[8:0], core_d_o[31:0], core_d_i[31:0]
//                                                     core memory-mapped port
//   out_valid_o / out_ready_i / out_spikes_o[31:0]   output spike word
//   busy_o                                            not in IDLE
// Optional macro CORE_SEQ_SPIKE_CNT_EN adds cnt_clr_i and cnt_o[255:0]
// (per-neuron 8-bit saturating spike counters).
//
// state | meaning
// IDLE  | ready for a frame
// SCAN  | one axon write per cycle, ascending
// DONE  | done_pic write on the bus
// WAIT  | bus idle while the core integrates
// READ  | output-word read on the bus
// CAPT  | read data arrives on core_d_i
// HOLD  | output word offered until accepted
//
// The core_* registers are loaded from the next-state decision, so the bus
// content always matches the current state (a write is on the bus during
// SCAN, the read during READ, and the read data is present during CAPT).
module core_spike_sequencer
  import core_seq_pkg::*;
#(
  parameter logic [ADDR_W-1:0] AXON_BASE     = 9'd0,
  parameter logic [ADDR_W-1:0] DONE_PIC_ADDR = DEF_DONE_PIC_ADDR,
  parameter logic [ADDR_W-1:0] OUT_ADDR      = DEF_OUT_ADDR,
  parameter logic [7:0]        DONE_WAIT     = 8'd4,
  parameter logic [31:0]       SPIKE_DATA    = 32'h1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 frame_valid_i,
  output logic                 frame_ready_o,
  input  logic [AXONS-1:0]     frame_i,
  output logic                 core_en_o,
  output logic                 core_we_o,
  output logic [ADDR_W-1:0]    core_addr_o,
  output logic [31:0]          core_d_o,
  input  logic [31:0]          core_d_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [NEURONS-1:0]   out_spikes_o,
  output logic                 busy_o
`ifdef CORE_SEQ_SPIKE_CNT_EN
  ,
  input  logic                 cnt_clr_i,
  output logic [NEURONS*8-1:0] cnt_o
`endif
);

  seq_state_e         state_q, state_nxt;
  logic [AXONS-1:0]   pend_q, pend_nxt;
  logic [7:0]         wait_q, wait_nxt;
  logic               en_nxt, we_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [31:0]        d_nxt;

  logic [AXONS-1:0]   enc_in;
  logic [7:0]         enc_idx;
  logic               enc_any;
  logic [AXONS-1:0]   enc_mask;

  // pend_q holds the axons not yet put on the bus, so in IDLE the first
  // write is chosen straight from the incoming frame.
  assign enc_in = (state_q == S_IDLE) ? frame_i : pend_q;

  lsb_prio_enc256 u_enc (
    .vec      (enc_in),
    .idx      (enc_idx),
    .any      (enc_any),
    .clr_mask (enc_mask)
  );

  assign frame_ready_o = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);

  always_comb begin
    state_nxt = state_q;
    pend_nxt  = pend_q;
    wait_nxt  = wait_q;
    en_nxt    = 1'b0;
    we_nxt    = 1'b0;
    addr_nxt  = '0;
    d_nxt     = '0;
    case (state_q)
      S_IDLE: begin
        if (frame_valid_i) begin
          if (enc_any) begin
            en_nxt    = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = axon_addr(AXON_BASE, enc_idx);
            d_nxt     = SPIKE_DATA;
            pend_nxt  = frame_i & ~enc_mask;
            state_nxt = S_SCAN;
          end else begin
            en_nxt    = 1'b1;
            we_nxt    = 1'b1;
            addr_nxt  = DONE_PIC_ADDR;
            pend_nxt  = '0;
            state_nxt = S_DONE;
          end
        end
      end
      S_SCAN: begin
        if (enc_any) begin
          en_nxt   = 1'b1;
          we_nxt   = 1'b1;
          addr_nxt = axon_addr(AXON_BASE, enc_idx);
          d_nxt    = SPIKE_DATA;
          pend_nxt = pend_q & ~enc_mask;
        end else begin
          en_nxt    = 1'b1;
          we_nxt    = 1'b1;
          addr_nxt  = DONE_PIC_ADDR;
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        wait_nxt  = DONE_WAIT;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (wait_q == 8'd1) begin
          wait_nxt  = '0;
          en_nxt    = 1'b1;
          addr_nxt  = OUT_ADDR;
          state_nxt = S_READ;
        end else begin
          wait_nxt = wait_q - 8'd1;
        end
      end
      S_READ: state_nxt = S_CAPT;
      S_CAPT: state_nxt = S_HOLD;
      S_HOLD: if (out_ready_i) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      pend_q       <= '0;
      wait_q       <= '0;
      core_en_o    <= 1'b0;
      core_we_o    <= 1'b0;
      core_addr_o  <= '0;
      core_d_o     <= '0;
      out_valid_o  <= 1'b0;
      out_spikes_o <= '0;
    end else begin
      state_q     <= state_nxt;
      pend_q      <= pend_nxt;
      wait_q      <= wait_nxt;
      core_en_o   <= en_nxt;
      core_we_o   <= we_nxt;
      core_addr_o <= addr_nxt;
      core_d_o    <= d_nxt;
      if (state_q == S_CAPT) begin
        out_spikes_o <= core_d_i;
        out_valid_o  <= 1'b1;
      end else if (state_q == S_HOLD && out_ready_i) begin
        out_valid_o <= 1'b0;
      end
    end
  end

`ifdef CORE_SEQ_SPIKE_CNT_EN
  for (genvar k = 0; k < NEURONS; k++) begin : g_cnt
    logic [7:0] cnt_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_q <= '0;
      end else if (cnt_clr_i) begin
        cnt_q <= '0;
      end else if (state_q == S_CAPT && core_d_i[k] && cnt_q != 8'hFF) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end
    assign cnt_o[k*8 +: 8] = cnt_q;
  end
`endif

`ifndef SYNTHESIS
  // Axon window must not overlap the done_pic address.
  ap_axon_below_done: assert property (@(posedge clk_i) disable iff (rst_i)
    (({1'b0, AXON_BASE} + 10'd255) < {1'b0, DONE_PIC_ADDR}));
`endif

endmodule
